// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller for an RV32I pipeline.
// Accepts one request at a time and classifies it as illegal, misaligned or
// legal. A legal request runs a single data-memory access with byte enables
// and lane-replicated store data. Loads are formatted with sign or zero
// extension. The access gives up with a timeout error when no ack arrives.
//
// Ports:
//   clk, i_rst_n          clock, synchronous active-low reset
//   i_req_valid/o_req_ready, i_req_we, i_funct3, i_addr, i_wdata
//                         request handshake and payload
//   o_resp_valid, o_rdata, o_err
//                         one-cycle completion with result and error code
//   o_mem_read_en, o_mem_write_en, o_mem_addr, o_mem_wdata, o_mem_be,
//   i_mem_rdata, i_mem_ack
//                         data-memory access port
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_err,
  output logic        o_mem_read_en,
  output logic        o_mem_write_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    lsb_q;

  logic          illegal, misaligned, cnt_last;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   shifted, fmt;

  // Request classification; illegal is tested before misaligned so it wins.
  always_comb begin
    illegal    = i_req_we ? (i_funct3 >= 3'd3)
                          : (i_funct3 == 3'd3 || i_funct3 == 3'd6 || i_funct3 == 3'd7);
    misaligned = 1'b0;
    if (i_funct3[1:0] == 2'd1) misaligned = i_addr[0];
    if (i_funct3[1:0] == 2'd2) misaligned = (i_addr[1:0] != 2'd0);
  end

  // Byte enables and lane replication depend only on the access size bits.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = i_wdata;
    case (i_funct3[1:0])
      2'd0: begin
        be_nxt    = 4'b0001 << i_addr[1:0];
        wdata_nxt = {4{i_wdata[7:0]}};
      end
      2'd1: begin
        be_nxt    = 4'b0011 << i_addr[1:0];
        wdata_nxt = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = i_mem_rdata >> {lsb_q, 3'b000};
    case (f3_q)
      3'd0:    fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    fmt = {24'd0, shifted[7:0]};
      3'd5:    fmt = {16'd0, shifted[15:0]};
      default: fmt = shifted;
    endcase
  end

  assign cnt_last = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req_valid) state_nxt = (illegal || misaligned) ? RESP : ACCESS;
      ACCESS:  if (i_mem_ack || cnt_last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      lsb_q       <= '0;
      o_rdata     <= '0;
      o_err       <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            we_q        <= i_req_we;
            f3_q        <= i_funct3;
            lsb_q       <= i_addr[1:0];
            o_mem_addr  <= {i_addr[31:2], 2'b00};
            o_mem_be    <= be_nxt;
            o_mem_wdata <= wdata_nxt;
            cnt         <= '0;
            // Error results are written here since these requests skip ACCESS.
            if (illegal) begin
              o_rdata <= '0;
              o_err   <= 2'd2;
            end else if (misaligned) begin
              o_rdata <= '0;
              o_err   <= 2'd1;
            end
          end
        end
        ACCESS: begin
          if (i_mem_ack) begin
            o_rdata <= we_q ? '0 : fmt;
            o_err   <= 2'd0;
          end else if (cnt_last) begin
            o_rdata <= '0;
            o_err   <= 2'd3;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready    = (state == IDLE);
  assign o_resp_valid   = (state == RESP);
  assign o_mem_read_en  = (state == ACCESS) && !we_q;
  assign o_mem_write_en = (state == ACCESS) && we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven bench for lsu_ctrl with a response scoreboard.
module tb_lsu_ctrl;

  localparam int unsigned TO = 16;
  localparam int NOACK = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [1:0]  err;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_resp_valid(resp_valid), .o_rdata(rdata), .o_err(err),
    .o_mem_read_en(mem_re), .o_mem_write_en(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;     // word returned by memory
    int          dly;     // ACCESS cycles before ack, NOACK = never
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_maddr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_lat;   // cycles from accept edge to resp
    int          e_strb;  // strobe cycles expected
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   strb = 0;
    bit   done = 0;
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_0000;
    e.rdata = v.e_rdata; e.err = v.e_err; e.lat = v.e_lat;
    sb.push_back(e);
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      // scrambled payload while busy must not matter
      req_valid = 1'b0; funct3 = 3'd7; addr = 32'hFFFF_FFFF; wdata = '0;
      mem_ack = 1'b0;
      if (resp_valid) begin
        exp_t x;
        done = 1;
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL sb_empty: got resp expected none");
        end else begin
          x = sb.pop_front();
          chk("rdata", rdata, x.rdata);
          chk("err", 32'(err), 32'(x.err));
          chk("latency", 32'(cyc), 32'(x.lat));
        end
        chk("strobe_cycles", 32'(strb), 32'(v.e_strb));
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("rdata_held", rdata, v.e_rdata);
      end else if (mem_re || mem_we) begin
        if (strb == 0) begin
          chk("mem_dir", {30'd0, mem_we, mem_re}, v.we ? 32'd2 : 32'd1);
          chk("mem_addr", mem_addr, v.e_maddr);
          chk("mem_be", 32'(mem_be), 32'(v.e_be));
          if (v.we) chk("mem_wdata", mem_wdata, v.e_wdata);
        end else if (mem_re && mem_we) begin
          chk("both_strobes", 32'd1, 32'd0);
        end
        if (cyc - 1 == v.dly) begin
          mem_ack = 1'b1; mem_rdata = v.mrd;
        end
        strb++;
      end
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL resp_wait: got no resp expected resp within 40 cycles");
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] mrd, int dly, logic [1:0] ee, logic [31:0] erd,
                              logic [31:0] ema, logic [3:0] ebe, logic [31:0] ewd,
                              int elat, int estrb);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd; v.dly = dly;
    v.e_err = ee; v.e_rdata = erd; v.e_maddr = ema; v.e_be = ebe; v.e_wdata = ewd;
    v.e_lat = elat; v.e_strb = estrb;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    //            we f3  addr        wdata         mrd           dly    err rdata         maddr         be       wdata         lat strb
    tbl.push_back(mk(0, 0, 32'h103,  32'h0,        32'h80FF_1234, 0,     0, 32'hFFFF_FF80, 32'h100,      4'b1000, 32'h0,        2, 1));
    tbl.push_back(mk(1, 1, 32'h22,   32'h0000_BEEF, 32'h1111_1111, 0,    0, 32'h0,         32'h20,       4'b1100, 32'hBEEF_BEEF, 2, 1));
    tbl.push_back(mk(0, 2, 32'h6,    32'h0,        32'h0,         0,     1, 32'h0,         32'h0,        4'b0,    32'h0,        1, 0));
    tbl.push_back(mk(0, 6, 32'h0,    32'h0,        32'h0,         0,     2, 32'h0,         32'h0,        4'b0,    32'h0,        1, 0));
    tbl.push_back(mk(0, 2, 32'h40,   32'h0,        32'h0,         NOACK, 3, 32'h0,         32'h40,       4'b1111, 32'h0,        TO + 1, TO));
    tbl.push_back(mk(0, 1, 32'h2,    32'h0,        32'h8001_0000, 2,     0, 32'hFFFF_8001, 32'h0,        4'b1100, 32'h0,        4, 3));
    tbl.push_back(mk(0, 4, 32'h1,    32'h0,        32'h1234_8056, 0,     0, 32'h0000_0080, 32'h0,        4'b0010, 32'h0,        2, 1));
    tbl.push_back(mk(1, 0, 32'h3,    32'hAABB_CC5A, 32'h0,        1,     0, 32'h0,         32'h0,        4'b1000, 32'h5A5A_5A5A, 3, 2));
    tbl.push_back(mk(1, 2, 32'h8,    32'hDEAD_BEEF, 32'h0,        0,     0, 32'h0,         32'h8,        4'b1111, 32'hDEAD_BEEF, 2, 1));
    tbl.push_back(mk(1, 3, 32'h1,    32'h0,        32'h0,         0,     2, 32'h0,         32'h0,        4'b0,    32'h0,        1, 0));
    tbl.push_back(mk(0, 1, 32'h1,    32'h0,        32'h0,         0,     1, 32'h0,         32'h0,        4'b0,    32'h0,        1, 0));
    tbl.push_back(mk(0, 5, 32'h3,    32'h0,        32'h0,         0,     1, 32'h0,         32'h0,        4'b0,    32'h0,        1, 0));
    tbl.push_back(mk(0, 2, 32'h10,   32'h0,        32'hCAFE_F00D, 0,     0, 32'hCAFE_F00D, 32'h10,       4'b1111, 32'h0,        2, 1));
    tbl.push_back(mk(1, 5, 32'h0,    32'h0,        32'h0,         0,     2, 32'h0,         32'h0,        4'b0,    32'h0,        1, 0));
    tbl.push_back(mk(0, 5, 32'h2,    32'h0,        32'h8001_0000, 0,     0, 32'h0000_8001, 32'h0,        4'b1100, 32'h0,        2, 1));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("idle_ack_resp", 32'(resp_valid), 32'd0);
    chk("idle_ack_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    chk("idle_ack_rdata", rdata, 32'd0);
    mem_ack = 1'b0;

    foreach (tbl[i]) run(tbl[i]);

    // reset during the second ACCESS cycle aborts the access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; addr = 32'h80; mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_cyc1_re", 32'(mem_re), 32'd1);
    @(negedge clk);
    chk("abort_cyc2_re", 32'(mem_re), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    chk("abort_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_resp2", 32'(resp_valid), 32'd0);
    run(mk(0, 5, 32'h2, 32'h0, 32'h8001_0000, 0, 0, 32'h0000_8001, 32'h0, 4'b1100, 32'h0, 2, 1));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
